segre_mm_arbiter: RTL and testbench
===================================

SEGRE_MM_ARBITER -- requirements
Module: segre_mm_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_SIZE, 32, address width in bits.
- LANE_SIZE, 128, cache lane width in bits.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  clock, single domain.
- rsn_i  in  1  reset, asynchronous, active-low.
- ic_req_i  in  1  instruction-cache miss refill request, level.
- ic_addr_i  in  ADDR_SIZE  instruction-cache lane address.
- dc_req_i  in  1  data-cache miss refill request, level.
- dc_addr_i  in  ADDR_SIZE  data-cache lane address.
- wb_req_i  in  1  data-cache dirty writeback request, level.
- wb_addr_i  in  ADDR_SIZE  writeback lane address.
- wb_data_i  in  LANE_SIZE  writeback lane data.
- ic_rdy_o  out  1  instruction-cache refill done, one-cycle pulse.
- dc_rdy_o  out  1  data-cache refill done, one-cycle pulse.
- wb_done_o  out  1  writeback accepted by memory, one-cycle pulse.
- rd_data_o  out  LANE_SIZE  refill lane, valid while ic_rdy_o or dc_rdy_o is high.
- mm_rd_o  out  1  main-memory read request.
- mm_wr_o  out  1  main-memory write request.
- mm_addr_o  out  ADDR_SIZE  read address.
- mm_wr_addr_o  out  ADDR_SIZE  write address.
- mm_wr_data_o  out  LANE_SIZE  write data.
- mm_data_rdy_i  in  1  memory completion, one cycle, for the read or write in flight.
- mm_rd_data_i  in  LANE_SIZE  read data, valid with mm_data_rdy_i.

Function
REQ-003 The FSM SHALL have four states: IDLE, WB, RD_DC, RD_IC. Only one memory transaction SHALL be in flight at a time.
REQ-004 In IDLE, grant SHALL be evaluated every cycle with this priority:
- First, wb_req_i -> WB.
- Otherwise, requests from ic and dc SHALL be served round-robin.
- A single requester SHALL be granted directly.
REQ-005 The round-robin pointer SHALL toggle to the other requester after every read grant. It SHALL favour dc after reset.
REQ-006 On grant, the address and write data SHALL be latched. mm_addr_o, mm_wr_addr_o and mm_wr_data_o SHALL come from these registers. Request-side input changes after grant SHALL have no effect.
REQ-007 mm_rd_o SHALL be high throughout RD_DC and RD_IC. mm_wr_o SHALL be high throughout WB. Both SHALL be low in IDLE and SHALL never be high together.
REQ-008 The first cycle mm_rd_o or mm_wr_o is high SHALL be the cycle after the grant decision. Request-to-issue latency SHALL be exactly 1 cycle from IDLE.
REQ-009 On mm_data_rdy_i in a read state, the block SHALL, in the next cycle:
- pulse the matching rdy output;
- drive rd_data_o with the registered mm_rd_data_i;
- return to IDLE.
REQ-010 On mm_data_rdy_i in WB, the block SHALL pulse wb_done_o in the next cycle and return to IDLE.
REQ-011 IDLE SHALL last at least one cycle between transactions. Back-to-back transactions SHALL therefore have a minimum 1-cycle gap with both mm_rd_o and mm_wr_o low.
REQ-012 mm_data_rdy_i SHALL be ignored in IDLE.
REQ-013 If a requester drops its request mid-transaction, the transaction SHALL still complete, and the rdy or done pulse SHALL still be issued.
REQ-014 If wb_req_i and dc_req_i are both high, WB SHALL be served first. A dirty victim is thus always written before the refill of the same set.
REQ-015 rd_data_o SHALL hold its last value when no rdy pulse is active.
REQ-016 A request still held after its rdy or done pulse SHALL be treated as a new request.

Reset
REQ-017 While rsn_i is low, all of the following SHALL hold asynchronously:
- state = IDLE;
- round-robin pointer = dc;
- all outputs = 0, including addresses and data.
REQ-018 Reset asserted mid-transaction SHALL abort it with no rdy or done pulse. After release, an outstanding mm_data_rdy_i SHALL be ignored.
REQ-019 Leaving reset, the first grant SHALL occur on the first rising clock edge with rsn_i high.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single dc: dc_req_i=1, dc_addr_i=0x100, memory responds 3 cycles later with 0xAA..AA -> mm_rd_o high for 4 cycles with mm_addr_o=0x100; dc_rdy_o pulses once with rd_data_o=0xAA..AA; ic_rdy_o stays 0.
- Contention: ic and dc both requested at reset release, addresses 0x200/0x300 -> dc served first (mm_addr_o=0x300), then ic (0x200), with a 1-cycle gap with both mm_rd_o and mm_wr_o low.
- Writeback priority: wb_req_i, dc_req_i and ic_req_i all high, wb_addr_i=0x400, wb_data_i=0x55..55 -> mm_wr_o first with mm_wr_addr_o=0x400 and mm_wr_data_o=0x55..55; then dc read; then ic read.
- Address change: dc_addr_i changed from 0x100 to 0x180 one cycle after grant -> mm_addr_o stays 0x100 until completion.
- Reset mid-read: rsn_i low during RD_IC, then mm_data_rdy_i after release -> no ic_rdy_o pulse; all outputs 0; state IDLE.
- Stray completion: mm_data_rdy_i pulsed in IDLE with no requests -> no rdy or done pulse; mm_rd_o and mm_wr_o remain 0.

Source files
------------

// File: rtl/segre_mm_arbiter.sv
// Main-memory arbiter for the instruction cache, the data cache and dirty writebacks.
// Only one memory transaction is in flight at a time. Writebacks win, and ic/dc refills alternate round-robin.
module segre_mm_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    input  logic                 dc_req_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic                 wb_req_i,
    input  logic [ADDR_SIZE-1:0] wb_addr_i,
    input  logic [LANE_SIZE-1:0] wb_data_i,
    output logic                 ic_rdy_o,
    output logic                 dc_rdy_o,
    output logic                 wb_done_o,
    output logic [LANE_SIZE-1:0] rd_data_o,
    output logic                 mm_rd_o,
    output logic                 mm_wr_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    output logic [ADDR_SIZE-1:0] mm_wr_addr_o,
    output logic [LANE_SIZE-1:0] mm_wr_data_o,
    input  logic                 mm_data_rdy_i,
    input  logic [LANE_SIZE-1:0] mm_rd_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD_DC,
        RD_IC
    } state_e;

    state_e               state_q, state_d;
    logic                 favour_dc_q, favour_dc_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [LANE_SIZE-1:0] wr_data_q, wr_data_d;
    logic [LANE_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 ic_rdy_q, ic_rdy_d;
    logic                 dc_rdy_q, dc_rdy_d;
    logic                 wb_done_q, wb_done_d;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= IDLE;
            favour_dc_q <= 1'b1;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            ic_rdy_q    <= 1'b0;
            dc_rdy_q    <= 1'b0;
            wb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            favour_dc_q <= favour_dc_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            ic_rdy_q    <= ic_rdy_d;
            dc_rdy_q    <= dc_rdy_d;
            wb_done_q   <= wb_done_d;
        end
    end

    // Completion returns to IDLE, so every transaction is followed by a one-cycle gap.
    always_comb begin
        state_d     = state_q;
        favour_dc_d = favour_dc_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_data_d   = rd_data_q;
        ic_rdy_d    = 1'b0;
        dc_rdy_d    = 1'b0;
        wb_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_req_i) begin
                    state_d   = WB;
                    wr_addr_d = wb_addr_i;
                    wr_data_d = wb_data_i;
                end else if (dc_req_i && (!ic_req_i || favour_dc_q)) begin
                    state_d     = RD_DC;
                    rd_addr_d   = dc_addr_i;
                    favour_dc_d = 1'b0;
                end else if (ic_req_i) begin
                    state_d     = RD_IC;
                    rd_addr_d   = ic_addr_i;
                    favour_dc_d = 1'b1;
                end
            end
            WB: begin
                if (mm_data_rdy_i) begin
                    state_d   = IDLE;
                    wb_done_d = 1'b1;
                end
            end
            RD_DC: begin
                if (mm_data_rdy_i) begin
                    state_d   = IDLE;
                    dc_rdy_d  = 1'b1;
                    rd_data_d = mm_rd_data_i;
                end
            end
            RD_IC: begin
                if (mm_data_rdy_i) begin
                    state_d   = IDLE;
                    ic_rdy_d  = 1'b1;
                    rd_data_d = mm_rd_data_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mm_rd_o      = (state_q == RD_DC) || (state_q == RD_IC);
    assign mm_wr_o      = (state_q == WB);
    assign mm_addr_o    = rd_addr_q;
    assign mm_wr_addr_o = wr_addr_q;
    assign mm_wr_data_o = wr_data_q;
    assign rd_data_o    = rd_data_q;
    assign ic_rdy_o     = ic_rdy_q;
    assign dc_rdy_o     = dc_rdy_q;
    assign wb_done_o    = wb_done_q;

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Self-checking bench for segre_mm_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model of the arbitration rules.
module tb_segre_mm_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk_i = 1'b0;
    logic          rsn_i;
    logic          ic_req_i, dc_req_i, wb_req_i;
    logic [AW-1:0] ic_addr_i, dc_addr_i, wb_addr_i;
    logic [LW-1:0] wb_data_i;
    logic          ic_rdy_o, dc_rdy_o, wb_done_o;
    logic [LW-1:0] rd_data_o;
    logic          mm_rd_o, mm_wr_o;
    logic [AW-1:0] mm_addr_o, mm_wr_addr_o;
    logic [LW-1:0] mm_wr_data_o;
    logic          mm_data_rdy_i;
    logic [LW-1:0] mm_rd_data_i;

    always #5 clk_i = ~clk_i;

    segre_mm_arbiter #(.ADDR_SIZE(AW), .LANE_SIZE(LW)) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .ic_req_i     (ic_req_i),
        .ic_addr_i    (ic_addr_i),
        .dc_req_i     (dc_req_i),
        .dc_addr_i    (dc_addr_i),
        .wb_req_i     (wb_req_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .ic_rdy_o     (ic_rdy_o),
        .dc_rdy_o     (dc_rdy_o),
        .wb_done_o    (wb_done_o),
        .rd_data_o    (rd_data_o),
        .mm_rd_o      (mm_rd_o),
        .mm_wr_o      (mm_wr_o),
        .mm_addr_o    (mm_addr_o),
        .mm_wr_addr_o (mm_wr_addr_o),
        .mm_wr_data_o (mm_wr_data_o),
        .mm_data_rdy_i(mm_data_rdy_i),
        .mm_rd_data_i (mm_rd_data_i)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: who owns memory, whose turn it is, and what each output should show.
    string         owner;
    bit            favourDc;
    logic [AW-1:0] expAddr, expWrAddr;
    logic [LW-1:0] expWrData, expRdData;
    logic          expIcRdy, expDcRdy, expWbDone;

    int cntRd, cntWr, cntIcRdy, cntDcRdy, cntWbDone;

    logic [LW-1:0] patA;
    logic [LW-1:0] pat5;

    task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        owner     = "";
        favourDc  = 1'b1;
        expAddr   = '0;
        expWrAddr = '0;
        expWrData = '0;
        expRdData = '0;
        expIcRdy  = 1'b0;
        expDcRdy  = 1'b0;
        expWbDone = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented in the current cycle.
    task automatic modelStep();
        if (rsn_i !== 1'b1) begin
            modelReset();
            return;
        end
        expIcRdy  = 1'b0;
        expDcRdy  = 1'b0;
        expWbDone = 1'b0;
        if (owner == "") begin
            if (wb_req_i) begin
                owner     = "wb";
                expWrAddr = wb_addr_i;
                expWrData = wb_data_i;
            end else if (dc_req_i && (!ic_req_i || favourDc)) begin
                owner    = "dc";
                expAddr  = dc_addr_i;
                favourDc = 1'b0;
            end else if (ic_req_i) begin
                owner    = "ic";
                expAddr  = ic_addr_i;
                favourDc = 1'b1;
            end
        end else if (mm_data_rdy_i) begin
            if (owner == "wb") expWbDone = 1'b1;
            if (owner == "dc") begin
                expDcRdy  = 1'b1;
                expRdData = mm_rd_data_i;
            end
            if (owner == "ic") begin
                expIcRdy  = 1'b1;
                expRdData = mm_rd_data_i;
            end
            owner = "";
        end
    endtask

    task automatic checkAll();
        checkOutput("mm_rd_o", LW'(mm_rd_o), LW'(owner == "dc" || owner == "ic"));
        checkOutput("mm_wr_o", LW'(mm_wr_o), LW'(owner == "wb"));
        checkOutput("mm_addr_o", LW'(mm_addr_o), LW'(expAddr));
        checkOutput("mm_wr_addr_o", LW'(mm_wr_addr_o), LW'(expWrAddr));
        checkOutput("mm_wr_data_o", mm_wr_data_o, expWrData);
        checkOutput("rd_data_o", rd_data_o, expRdData);
        checkOutput("ic_rdy_o", LW'(ic_rdy_o), LW'(expIcRdy));
        checkOutput("dc_rdy_o", LW'(dc_rdy_o), LW'(expDcRdy));
        checkOutput("wb_done_o", LW'(wb_done_o), LW'(expWbDone));
        checkOutput("rd_wr_exclusive", LW'(mm_rd_o & mm_wr_o), '0);
    endtask

    task automatic clearCounts();
        cntRd     = 0;
        cntWr     = 0;
        cntIcRdy  = 0;
        cntDcRdy  = 0;
        cntWbDone = 0;
    endtask

    // One clock: update the model, cross the edge, sample 1 ns later and compare.
    task automatic tick();
        modelStep();
        @(posedge clk_i);
        #1;
        cntRd     += int'(mm_rd_o);
        cntWr     += int'(mm_wr_o);
        cntIcRdy  += int'(ic_rdy_o);
        cntDcRdy  += int'(dc_rdy_o);
        cntWbDone += int'(wb_done_o);
        checkAll();
    endtask

    task automatic applyStimulus(input logic ic, input logic [AW-1:0] icAddr,
                                 input logic dc, input logic [AW-1:0] dcAddr,
                                 input logic wb, input logic [AW-1:0] wbAddr,
                                 input logic [LW-1:0] wbData,
                                 input logic rdy, input logic [LW-1:0] rdData);
        ic_req_i      = ic;
        ic_addr_i     = icAddr;
        dc_req_i      = dc;
        dc_addr_i     = dcAddr;
        wb_req_i      = wb;
        wb_addr_i     = wbAddr;
        wb_data_i     = wbData;
        mm_data_rdy_i = rdy;
        mm_rd_data_i  = rdData;
    endtask

    task automatic assertResetNow();
        rsn_i = 1'b0;
        #1;
        modelReset();
        checkAll();
    endtask

    initial begin
        patA = {16{8'hAA}};
        pat5 = {16{8'h55}};
        rsn_i = 1'b0;
        applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, '0);
        clearCounts();
        #1;
        modelReset();
        checkAll();
        tick();
        tick();

        $display("[TB] single dc refill");
        rsn_i = 1'b1;
        applyStimulus(0, '0, 1, 32'h100, 0, '0, '0, 0, '0);
        clearCounts();
        tick();
        checkOutput("s1_addr", LW'(mm_addr_o), LW'(32'h100));
        applyStimulus(0, '0, 0, 32'h100, 0, '0, '0, 0, '0);
        tick();
        tick();
        tick();
        applyStimulus(0, '0, 0, 32'h100, 0, '0, '0, 1, patA);
        tick();
        checkOutput("s1_rd_data", rd_data_o, patA);
        checkOutput("s1_dc_pulse", LW'(dc_rdy_o), LW'(1'b1));
        applyStimulus(0, '0, 0, 32'h100, 0, '0, '0, 0, '0);
        tick();
        tick();
        checkOutput("s1_rd_cycles", LW'(cntRd), LW'(4));
        checkOutput("s1_dc_pulses", LW'(cntDcRdy), LW'(1));
        checkOutput("s1_ic_pulses", LW'(cntIcRdy), LW'(0));

        $display("[TB] contention at reset release");
        assertResetNow();
        applyStimulus(1, 32'h200, 1, 32'h300, 0, '0, '0, 0, '0);
        tick();
        rsn_i = 1'b1;
        clearCounts();
        tick();
        checkOutput("s2_first_dc", LW'(mm_addr_o), LW'(32'h300));
        applyStimulus(1, 32'h200, 0, 32'h300, 0, '0, '0, 1, 128'h1234);
        tick();
        checkOutput("s2_gap_rd", LW'(mm_rd_o), LW'(1'b0));
        checkOutput("s2_gap_wr", LW'(mm_wr_o), LW'(1'b0));
        applyStimulus(1, 32'h200, 0, 32'h300, 0, '0, '0, 0, '0);
        tick();
        checkOutput("s2_then_ic", LW'(mm_addr_o), LW'(32'h200));
        applyStimulus(0, 32'h200, 0, 32'h300, 0, '0, '0, 1, 128'h5678);
        tick();
        applyStimulus(0, 32'h200, 0, 32'h300, 0, '0, '0, 0, '0);
        tick();
        checkOutput("s2_dc_pulses", LW'(cntDcRdy), LW'(1));
        checkOutput("s2_ic_pulses", LW'(cntIcRdy), LW'(1));

        $display("[TB] writeback priority");
        applyStimulus(1, 32'h600, 1, 32'h500, 1, 32'h400, pat5, 0, '0);
        tick();
        checkOutput("s3_wr", LW'(mm_wr_o), LW'(1'b1));
        checkOutput("s3_wr_addr", LW'(mm_wr_addr_o), LW'(32'h400));
        checkOutput("s3_wr_data", mm_wr_data_o, pat5);
        applyStimulus(1, 32'h600, 1, 32'h500, 0, 32'h400, pat5, 1, '0);
        tick();
        checkOutput("s3_wb_done", LW'(wb_done_o), LW'(1'b1));
        applyStimulus(1, 32'h600, 1, 32'h500, 0, 32'h400, pat5, 0, '0);
        tick();
        checkOutput("s3_dc_next", LW'(mm_addr_o), LW'(32'h500));
        applyStimulus(1, 32'h600, 0, 32'h500, 0, 32'h400, pat5, 1, 128'h9);
        tick();
        applyStimulus(1, 32'h600, 0, 32'h500, 0, 32'h400, pat5, 0, '0);
        tick();
        checkOutput("s3_ic_last", LW'(mm_addr_o), LW'(32'h600));
        applyStimulus(0, 32'h600, 0, 32'h500, 0, 32'h400, pat5, 1, 128'hA);
        tick();
        applyStimulus(0, 32'h600, 0, 32'h500, 0, 32'h400, pat5, 0, '0);
        tick();

        $display("[TB] address change after grant");
        applyStimulus(0, '0, 1, 32'h100, 0, '0, '0, 0, '0);
        tick();
        applyStimulus(0, '0, 0, 32'h180, 0, '0, '0, 0, '0);
        tick();
        checkOutput("s4_addr_hold1", LW'(mm_addr_o), LW'(32'h100));
        tick();
        checkOutput("s4_addr_hold2", LW'(mm_addr_o), LW'(32'h100));
        applyStimulus(0, '0, 0, 32'h180, 0, '0, '0, 1, 128'hB);
        tick();
        applyStimulus(0, '0, 0, 32'h180, 0, '0, '0, 0, '0);
        tick();

        $display("[TB] reset in the middle of an ic read");
        applyStimulus(1, 32'h700, 0, '0, 0, '0, '0, 0, '0);
        tick();
        checkOutput("s5_rd_ic", LW'(mm_rd_o), LW'(1'b1));
        applyStimulus(0, 32'h700, 0, '0, 0, '0, '0, 0, '0);
        tick();
        assertResetNow();
        checkOutput("s5_addr_zero", LW'(mm_addr_o), '0);
        checkOutput("s5_data_zero", rd_data_o, '0);
        tick();
        rsn_i = 1'b1;
        clearCounts();
        applyStimulus(0, 32'h700, 0, '0, 0, '0, '0, 1, patA);
        tick();
        applyStimulus(0, 32'h700, 0, '0, 0, '0, '0, 0, '0);
        tick();
        checkOutput("s5_no_ic_pulse", LW'(cntIcRdy), LW'(0));
        checkOutput("s5_no_rd", LW'(cntRd), LW'(0));

        $display("[TB] stray completion in idle");
        clearCounts();
        applyStimulus(0, '0, 0, '0, 0, '0, '0, 1, patA);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0, 0, '0);
        tick();
        checkOutput("s6_pulses", LW'(cntIcRdy + cntDcRdy + cntWbDone), LW'(0));
        checkOutput("s6_mem_idle", LW'(cntRd + cntWr), LW'(0));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rsn_i = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            applyStimulus($urandom_range(0, 1) == 1, $urandom,
                          $urandom_range(0, 1) == 1, $urandom,
                          $urandom_range(0, 4) == 0, $urandom,
                          {$urandom, $urandom, $urandom, $urandom},
                          $urandom_range(0, 2) == 0,
                          {$urandom, $urandom, $urandom, $urandom});
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
